// File: rtl/mdu_pkg.sv
// ============================================================================
// Module  : mdu_pkg
// Brief   : Shared types for the iterative multiply/divide unit: operation
//           encoding, FSM state encoding and the default operand width.
//           Also used by the decode stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  // All divide-class operations have the top opcode bit set.
  function automatic logic op_is_div(input mdu_op_e op);
    return op[2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/iter_mdu.sv
// ============================================================================
// Module  : iter_mdu
// Brief   : Iterative radix-2 multiply/divide unit. XLEN shift-add or
//           restoring-divide steps on operand magnitudes, one sign-fix cycle,
//           then the result is held until the consumer accepts it.
//           Latency from accept to out_valid is exactly XLEN+1 edges.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module iter_mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            Zero,
  output logic            busy
);

  localparam int                c_cnt_w = $clog2(XLEN + 1);
  localparam logic [c_cnt_w-1:0] c_iters = c_cnt_w'(XLEN);

  mdu_state_e         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  mdu_op_e            r_op;
  logic [XLEN-1:0]    r_hi;    // product high half / partial remainder
  logic [XLEN-1:0]    r_lo;    // multiplier->product low half / dividend->quotient
  logic [XLEN-1:0]    r_opb;   // multiplicand or divisor magnitude
  logic               r_neg;   // final result must be negated
  logic               r_div0;  // divisor was zero

  // ---------------------------------------------------------------------------
  // Request decode: which operands are signed, and their magnitudes
  // ---------------------------------------------------------------------------
  mdu_op_e         w_op;
  logic            w_a_sgn;
  logic            w_b_sgn;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_neg_in;

  assign w_op = mdu_op_e'(op);

  // Operand signedness per operation; MUL low half is sign-agnostic.
  always_comb begin
    w_a_sgn = 1'b0;
    w_b_sgn = 1'b0;
    case (w_op)
      OP_MULH, OP_DIV, OP_REM: begin
        w_a_sgn = 1'b1;
        w_b_sgn = 1'b1;
      end
      OP_MULHSU: w_a_sgn = 1'b1;
      default: ;
    endcase
  end

  assign w_a_neg  = w_a_sgn & A[XLEN-1];
  assign w_b_neg  = w_b_sgn & B[XLEN-1];
  assign w_a_mag  = w_a_neg ? (~A + 1'b1) : A;
  assign w_b_mag  = w_b_neg ? (~B + 1'b1) : B;
  // Remainder follows the dividend sign; everything else the product sign.
  assign w_neg_in = (w_op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

  // ---------------------------------------------------------------------------
  // One radix-2 step
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_div_shift;
  logic [XLEN-1:0] w_div_diff;
  logic            w_div_ge;

  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
  assign w_div_shift = {r_hi, r_lo[XLEN-1]};
  // A true compare (not the borrow of a XLEN+1 subtract) keeps a zero
  // divisor well behaved: quotient bits all ones, remainder = dividend.
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
  assign w_div_diff  = w_div_shift[XLEN-1:0] - r_opb;

  // ---------------------------------------------------------------------------
  // Sign fix and result selection
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_q_fix;
  logic [XLEN-1:0]   w_r_fix;
  logic [XLEN-1:0]   w_res;

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg ? (~w_prod + 1'b1) : w_prod;
  assign w_q_fix    = r_neg ? (~r_lo + 1'b1) : r_lo;
  assign w_r_fix    = r_neg ? (~r_hi + 1'b1) : r_hi;

  // Pick the half/part of the datapath that the operation returns.
  always_comb begin
    w_res = '0;
    case (r_op)
      OP_MUL:                       w_res = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_res = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_res = r_div0 ? '1 : w_q_fix;
      default:                      w_res = w_r_fix;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers; every output is registered here
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_op      <= OP_MUL;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opb     <= '0;
      r_neg     <= 1'b0;
      r_div0    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      Result    <= '0;
      Zero      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            r_op     <= w_op;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_neg    <= w_neg_in;
            r_div0   <= (B == '0);
            if (op_is_div(w_op)) begin
              r_lo  <= w_a_mag;
              r_opb <= w_b_mag;
            end else begin
              r_lo  <= w_b_mag;
              r_opb <= w_a_mag;
            end
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= ST_CALC;
          end
        end

        ST_CALC: begin
          if (r_cnt != c_iters) begin
            r_cnt <= r_cnt + 1'b1;
            if (op_is_div(r_op)) begin
              r_hi <= w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0];
              r_lo <= {r_lo[XLEN-2:0], w_div_ge};
            end else begin
              r_hi <= w_mul_sum[XLEN:1];
              r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
            end
          end else begin
            Result    <= w_res;
            Zero      <= (w_res == '0);
            out_valid <= 1'b1;
            r_state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            Zero      <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iter_mdu.sv
// ============================================================================
// Module  : tb_iter_mdu
// Brief   : Self-checking bench for iter_mdu (XLEN=64): directed vectors,
//           randomized operations against an arithmetic reference model,
//           back-pressure, back-to-back requests and reset abort.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_iter_mdu;

  localparam int          W     = 64;
  localparam int          LAT   = W + 1;
  localparam logic [2:0]  T_MUL = 3'd0, T_MULH = 3'd1, T_MULHSU = 3'd2, T_MULHU = 3'd3;
  localparam logic [2:0]  T_DIV = 3'd4, T_DIVU = 3'd5, T_REM = 3'd6, T_REMU = 3'd7;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] Result;
  logic         Zero;
  logic         busy;

  int tests_run = 0;
  int tests_failed = 0;

  iter_mdu #(.XLEN(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Result   (Result),
    .Zero     (Zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference: plain wide/signed arithmetic following the operation rules.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0]     p;
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    case (o)
      T_MUL:    begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; return p[W-1:0]; end
      T_MULH:   begin p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b}; return p[2*W-1:W]; end
      T_MULHSU: begin p = {{W{a[W-1]}}, a} * {{W{1'b0}}, b}; return p[2*W-1:W]; end
      T_MULHU:  begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; return p[2*W-1:W]; end
      T_DIV:    begin
        if (b == 0) return ONES;
        if (a == MINV && b == ONES) return a;
        return sa / sb;
      end
      T_DIVU:   return (b == 0) ? ONES : a / b;
      T_REM:    begin
        if (b == 0) return a;
        if (a == MINV && b == ONES) return '0;
        return sa % sb;
      end
      default:  return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return ONES;
      2:       return MINV;
      3:       return W'($urandom_range(1, 20));
      4:       return -W'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue one request, then scramble the inputs and count edges to out_valid.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic z, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); A = {$urandom, $urandom}; B = {$urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    res = Result;
    z   = Zero;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({in_ready, out_valid, busy, Zero} !== 4'b1000 || Result !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b zero=%b result=%h, required 1 0 0 0 0",
               in_ready, out_valid, busy, Zero, Result);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [2:0]   ops [10] = '{T_MUL, T_MULH, T_MULHU, T_DIV, T_REM, T_DIVU, T_DIVU, T_REMU, T_DIV, T_REM};
    logic [W-1:0] as  [10] = '{64'd7, ONES, ONES, -64'd7, -64'd7, 64'd7, 64'd5, 64'd5, MINV, MINV};
    logic [W-1:0] bs  [10] = '{64'd6, ONES, ONES, 64'd2, 64'd2, 64'd2, 64'd0, 64'd0, ONES, ONES};
    logic [W-1:0] exp [10] = '{64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, -64'd3, ONES, 64'd3, ONES, 64'd5, MINV, 64'd0};
    logic [W-1:0] res;
    logic         z;
    int           lat;
    for (int i = 0; i < 10; i++) begin
      issue(ops[i], as[i], bs[i], res, z, lat);
      tests_run++;
      if (res !== exp[i] || z !== (exp[i] == 0) || lat != LAT) begin
        tests_failed++;
        $display("FAIL directed_%0d op=%0d: result=%h zero=%b latency=%0d, required %h %b %0d",
                 i, ops[i], res, z, lat, exp[i], exp[i] == 0, LAT);
      end
      release_result();
    end
  endtask

  task automatic test_random();
    logic [2:0]   o;
    logic [W-1:0] a, b, res, e;
    logic         z;
    int           lat;
    for (int i = 0; i < 48; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      e = model(o, a, b);
      issue(o, a, b, res, z, lat);
      tests_run++;
      if (res !== e || z !== (e == 0) || lat != LAT) begin
        tests_failed++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: result=%h zero=%b latency=%0d, required %h %b %0d",
                 i, o, a, b, res, z, lat, e, e == 0, LAT);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] res;
    logic         z;
    int           lat;
    issue(T_MUL, 64'd7, 64'd6, res, z, lat);
    tests_run++;
    if (res !== 64'd42 || lat != LAT) begin
      tests_failed++;
      $display("FAIL bp_result: result=%h latency=%0d, required 42 %0d", res, lat, LAT);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; op = T_DIV; A = {$urandom, $urandom}; B = {$urandom, $urandom};
      @(posedge clk); #1;
      tests_run++;
      if (Result !== 64'd42 || Zero !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: result=%h zero=%b in_ready=%b out_valid=%b busy=%b, required 42 0 0 1 1",
                 i, Result, Zero, in_ready, out_valid, busy);
      end
    end
    // in_valid stays high across the completion edge: it must not be taken.
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] res, e;
    logic         z;
    int           lat;
    for (int i = 0; i < 3; i++) begin
      e = model(T_DIVU, 64'd1000 + 64'(i), 64'd7);
      issue(T_DIVU, 64'd1000 + 64'(i), 64'd7, res, z, lat);
      tests_run++;
      if (res !== e || lat != LAT || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_%0d: result=%h latency=%0d in_ready=%b, required %h %0d 0", i, res, lat, in_ready, e, LAT);
      end
      release_result();
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_ready_%0d: in_ready=%b, required 1", i, in_ready);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] res;
    logic         z;
    int           lat;
    int           seen;
    in_valid = 1'b1; op = T_MUL; A = 64'd3; B = 64'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_busy: busy=%b in_ready=%b, required 1 0", busy, in_ready);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tests_run++;
    if ({in_ready, out_valid, busy, Zero} !== 4'b1000 || Result !== '0) begin
      tests_failed++;
      $display("FAIL abort_state: in_ready=%b out_valid=%b busy=%b zero=%b result=%h, required 1 0 0 0 0",
               in_ready, out_valid, busy, Zero, Result);
    end
    seen = 0;
    for (int i = 0; i < LAT + 5; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL abort_no_valid: out_valid cycles=%0d, required 0", seen);
    end
    issue(T_MULHSU, MINV, 64'd4, res, z, lat);
    tests_run++;
    if (res !== model(T_MULHSU, MINV, 64'd4) || lat != LAT) begin
      tests_failed++;
      $display("FAIL abort_recover: result=%h latency=%0d, required %h %0d",
               res, lat, model(T_MULHSU, MINV, 64'd4), LAT);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iter_mdu.md
ITER_MDU -- requirements
Module: iter_mdu

Interface
REQ-001 Parameter XLEN, default 64, operand/result width; legal values 8..64, even.
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  3  operation, encoding per mdu_pkg: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
REQ-007 A  input  XLEN  operand 1 (multiplicand/dividend).
REQ-008 B  input  XLEN  operand 2 (multiplier/divisor).
REQ-009 out_valid  output  1  Result valid.
REQ-010 out_ready  input  1  consumer accepts Result.
REQ-011 Result  output  XLEN  registered result.
REQ-012 Zero  output  1  high when Result == 0, qualified by out_valid.
REQ-013 busy  output  1  high in CALC or DONE.

Function
REQ-014 FSM states IDLE, CALC, DONE; in_ready = 1 only in IDLE.
REQ-015 Accept on a rising edge with in_valid && in_ready: op, A, B captured; state -> CALC; step counter cleared.
REQ-016 in_valid and operand changes outside IDLE are ignored; captured operands are not disturbed.
REQ-017 CALC performs exactly XLEN radix-2 iterations (shift-add multiply or restoring divide on magnitudes), then one sign-fix cycle, then DONE.
REQ-018 Fixed latency for every op, including divide-by-zero and overflow: out_valid rises on the (XLEN+1)th rising edge after the accept edge (65 for XLEN=64).
REQ-019 MUL returns low XLEN bits of the 2*XLEN product; MULH signed x signed, MULHSU signed A x unsigned B, MULHU unsigned x unsigned return high XLEN bits.
REQ-020 DIV/REM signed, quotient truncated toward zero, remainder takes sign of dividend; DIVU/REMU unsigned.
REQ-021 Divide by zero: DIV/DIVU Result = all ones; REM/REMU Result = A.
REQ-022 Signed overflow (A = most negative, B = -1): DIV Result = A; REM Result = 0.
REQ-023 In DONE, out_valid = 1, Result and Zero held stable until out_valid && out_ready on a rising edge, then -> IDLE.
REQ-024 in_ready stays 0 on the completion edge; next accept earliest one cycle after return to IDLE.
REQ-025 Zero is registered together with Result; no combinational path from inputs to any output.

Reset
REQ-026 rst_n low at a rising edge: state IDLE, in_ready 1, out_valid 0, busy 0, Result 0, Zero 0, counter 0.
REQ-027 Reset in CALC or DONE aborts the operation; no out_valid for the aborted request.
REQ-028 Reset takes priority over accept and completion on the same edge.

Structure
REQ-029 Package mdu_pkg holds op enum (3-bit), FSM state enum, and default XLEN constant; shared with decode stage.
REQ-030 Single module, FSM and datapath together; no sub-module; counter width $clog2(XLEN+1).

Verification (XLEN=64)
REQ-031 MUL A=7 B=6 -> Result 42, Zero 0, out_valid exactly 65 edges after accept.
REQ-032 MULH A=-1 B=-1 -> Result 0, Zero 1; MULHU A=B=all ones -> Result 0xFFFF_FFFF_FFFF_FFFE.
REQ-033 DIV A=-7 B=2 -> -3; REM A=-7 B=2 -> -1; DIVU A=7 B=2 -> 3.
REQ-034 DIVU A=5 B=0 -> all ones; REMU A=5 B=0 -> 5; DIV A=0x8000_0000_0000_0000 B=-1 -> A; REM same -> 0.
REQ-035 out_ready held low 10 cycles in DONE with in_valid pulsing -> Result/Zero stable, in_ready 0, no second accept; out_ready high -> IDLE next edge.
REQ-036 rst_n low for one edge at counter=30 in CALC -> next cycle in_ready 1, out_valid 0, busy 0; following request completes normally.
